// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers execute (1-entry skid) and load (2-entry FIFO) results,
// drives one registered register-file write per cycle and tracks pending writes.
module wb_arbiter #(
    parameter int MEM_BURST_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic [3:0]  ex_idx_i,
    input  logic [31:0] ex_data_i,
    input  logic [1:0]  ex_scope_i,
    input  logic        mem_valid_i,
    output logic        mem_ready_o,
    input  logic [3:0]  mem_idx_i,
    input  logic [31:0] mem_data_i,
    input  logic [1:0]  mem_scope_i,
    input  logic        issue_set_i,
    input  logic [3:0]  issue_idx_i,
    output logic [15:0] busy_o,
    output logic [3:0]  reg_w_idx_o,
    output logic [31:0] wdata_o,
    output logic        wen_o,
    output logic [1:0]  wr_scope_o
);

    localparam logic [2:0] BURST_MAX = 3'(MEM_BURST_MAX);

    // Handshakes: a source transfers on an edge where valid & ready are both high.
    // Ready depends only on local buffer occupancy and rst_n, never on valid.
    logic        ex_full;
    logic [3:0]  ex_idx_q;
    logic [31:0] ex_data_q;
    logic [1:0]  ex_scope_q;

    logic [3:0]  mem_idx_q   [2];
    logic [31:0] mem_data_q  [2];
    logic [1:0]  mem_scope_q [2];
    logic        mem_rd_ptr;
    logic        mem_wr_ptr;
    logic [1:0]  mem_count;

    logic [2:0]  streak;
    logic        out_valid;

    logic        ex_push;
    logic        mem_push;
    logic        mem_nonempty;
    logic        grant_ex;
    logic        grant_mem;
    logic [3:0]  sel_idx;
    logic [31:0] sel_data;
    logic [1:0]  sel_scope;
    logic [15:0] busy_next;

    assign ex_ready_o   = rst_n & ~ex_full;
    assign mem_ready_o  = rst_n & (mem_count < 2'd2);
    assign ex_push      = ex_valid_i & ex_ready_o;
    assign mem_push     = mem_valid_i & mem_ready_o;
    assign mem_nonempty = (mem_count != 2'd0);

    // Memory is favoured until it has taken BURST_MAX grants over a waiting ex entry.
    always_comb begin
        grant_ex  = 1'b0;
        grant_mem = 1'b0;
        if (ex_full && mem_nonempty) begin
            if (streak == BURST_MAX) grant_ex = 1'b1;
            else                     grant_mem = 1'b1;
        end else if (ex_full) begin
            grant_ex = 1'b1;
        end else if (mem_nonempty) begin
            grant_mem = 1'b1;
        end
    end

    always_comb begin
        sel_idx   = ex_idx_q;
        sel_data  = ex_data_q;
        sel_scope = ex_scope_q;
        if (grant_mem) begin
            sel_idx   = mem_idx_q[mem_rd_ptr];
            sel_data  = mem_data_q[mem_rd_ptr];
            sel_scope = mem_scope_q[mem_rd_ptr];
        end
    end

    // A set in the same cycle as the clear of that index must win, so it is applied last.
    always_comb begin
        busy_next = busy_o;
        if (out_valid)   busy_next[reg_w_idx_o] = 1'b0;
        if (issue_set_i) busy_next[issue_idx_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (mem_push) begin
            mem_idx_q[mem_wr_ptr]   <= mem_idx_i;
            mem_data_q[mem_wr_ptr]  <= mem_data_i;
            mem_scope_q[mem_wr_ptr] <= mem_scope_i;
        end
        if (ex_push) begin
            ex_idx_q   <= ex_idx_i;
            ex_data_q  <= ex_data_i;
            ex_scope_q <= ex_scope_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_full     <= 1'b0;
            mem_rd_ptr  <= 1'b0;
            mem_wr_ptr  <= 1'b0;
            mem_count   <= 2'd0;
            streak      <= 3'd0;
            out_valid   <= 1'b0;
            wen_o       <= 1'b0;
            reg_w_idx_o <= 4'd0;
            wdata_o     <= 32'd0;
            wr_scope_o  <= 2'd0;
            busy_o      <= 16'd0;
        end else begin
            // ex_push requires an empty slot and grant_ex a full one, so they never collide.
            if (grant_ex) ex_full <= 1'b0;
            if (ex_push)  ex_full <= 1'b1;

            if (mem_push)  mem_wr_ptr <= ~mem_wr_ptr;
            if (grant_mem) mem_rd_ptr <= ~mem_rd_ptr;
            mem_count <= mem_count + {1'b0, mem_push} - {1'b0, grant_mem};

            if (grant_ex) begin
                streak <= 3'd0;
            end else if (grant_mem) begin
                if (!ex_full)                streak <= 3'd0;
                else if (streak < BURST_MAX) streak <= streak + 3'd1;
            end

            out_valid <= grant_ex | grant_mem;
            wen_o     <= (grant_ex | grant_mem) & (sel_scope != 2'b00);
            if (grant_ex | grant_mem) begin
                reg_w_idx_o <= sel_idx;
                wdata_o     <= sel_data;
                wr_scope_o  <= sel_scope;
            end

            busy_o <= busy_next;
        end
    end

endmodule
